muldiv_seq_unit: RTL and testbench
==================================

# muldiv_seq_unit

Parametrised iterative multiply/divide engine with built-in HI/LO registers. It replaces the combinational MULT/DIV units and the separate hi/lo registers in the next-generation MIPS core. It executes MULT/MULTU/DIV/DIVU over a fixed XLEN+1 cycle latency with a busy/done handshake, and serves MTHI/MTLO/MFHI/MFLO directly.

## Interface
- XLEN, 32, operand/HI/LO width; even, ≥ 4.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not overridden).

- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start.
- op1  in  XLEN  rs operand (multiplicand / dividend); sampled with start.
- op2  in  XLEN  rt operand (multiplier / divisor); sampled with start.
- flush  in  1  synchronous abort of an in-flight operation.
- hi_write  in  1  MTHI: HI <= wr_data.
- lo_write  in  1  MTLO: LO <= wr_data.
- wr_data  in  XLEN  move data (rs).
- busy  out  1  operation in flight; core stalls MFHI/MFLO and new mult/div.
- done  out  1  one-cycle pulse; HI/LO hold the new result.
- div_by_zero  out  1  pulses with done when a DIV/DIVU divisor was 0.
- hi_out  out  XLEN  HI register.
- lo_out  out  XLEN  LO register.

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN on start.
  - RUN → FIX when count == XLEN-1.
  - FIX → IDLE always.
  - RUN/FIX → IDLE on flush.
- Capture at start:
  - signed ops (MULT, DIV) load magnitudes |op1| and |op2| and record the result signs:
    - product/quotient negative = op1[XLEN-1] ^ op2[XLEN-1];
    - remainder negative = op1[XLEN-1].
  - Unsigned ops load operands as-is.
  - count <= 0.
- Magnitude arithmetic is unsigned XLEN-bit, so |MIN| = 2^(XLEN-1) is exact.
- MULT/MULTU: radix-2 shift-add, one multiplier bit per RUN cycle, into a 2·XLEN accumulator.
- DIV/DIVU: radix-2 restoring division, one quotient bit per RUN cycle.
  - Partial remainder is XLEN+1 bits.
  - Quotient is shifted into the low half.
- FIX:
  - Apply 2's-complement negation per recorded sign: full 2·XLEN for products, each half separately for quotient/remainder.
  - Write HI/LO:
    - mult: HI = product[2XLEN-1:XLEN], LO = product[XLEN-1:0];
    - div: HI = remainder, LO = quotient.
  - Assert done for exactly one cycle.
- Divide by zero (op2 == 0):
  - Full latency still elapses.
  - HI = op1 as captured (raw, not magnitude), LO = all ones, regardless of signedness.
  - div_by_zero = 1 alongside done.
- Overflow MIN / -1: LO = MIN, HI = 0; no flag.
- start while busy: ignored, with no effect on the in-flight op.
- hi_write/lo_write while busy: ignored.
- hi_write/lo_write in IDLE, including the same cycle as start: applied at that edge; the result later overwrites.
- flush:
  - returns to IDLE at the next edge;
  - HI/LO are unchanged;
  - no done is produced;
  - a start sampled in the same cycle is ignored.
- flush in IDLE: no effect.

## Timing
- Reset (async) values: busy 0, done 0, div_by_zero 0, hi_out 0, lo_out 0, state IDLE, count 0.
- Edge E0 samples start; busy = 1 from E0.
- RUN occupies edges E1..E_XLEN, one iteration per edge.
- Edge E_{XLEN+1} (FIX):
  - HI/LO update;
  - done = 1 and busy = 0 for the cycle following;
  - done/div_by_zero return to 0 at E_{XLEN+2}.
- Latency: XLEN+1 cycles from the accept edge to valid HI/LO (33 for XLEN=32).
- Back-to-back: a start asserted in the done cycle is accepted at that edge.
- hi_out/lo_out are register outputs with no combinational path from inputs.
- Reset asserted mid-operation forces all state to its reset value immediately. The first start after rst_n rises behaves normally.

## Test plan
- MULT op1=0xFFFFFFFD (-3), op2=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; done exactly 33 cycles after the accept edge; busy high 33 cycles.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001. Then MULT with the same operands → HI=0, LO=1.
- DIV -7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 7/-2 → LO=0xFFFFFFFD, HI=1.
- DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0, div_by_zero=0. DIVU 5/0 → HI=5, LO=0xFFFFFFFF, div_by_zero=1 with done.
- Handshake/boundaries:
  - MTHI 0x1234 in IDLE → hi_out=0x1234 next cycle;
  - start and MTLO during RUN are ignored;
  - flush at cycle 10 → busy falls, no done, HI/LO keep their prior values;
  - start in the done cycle is accepted.
- Drop rst_n at cycle 15 of a DIV → all outputs 0 immediately. After release, MULTU 3×4 → LO=12, HI=0 at the normal latency.

Source files
------------

// File: rtl/muldiv_seq_unit_if.sv
// Bus between the core and the iterative mult/div unit.
// Request, HI/LO move and result signals in one bundle.
interface muldiv_seq_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            flush;
    logic            hi_write;
    logic            lo_write;
    logic [XLEN-1:0] wr_data;
    logic            busy;
    logic            done;
    logic            div_by_zero;
    logic [XLEN-1:0] hi_out;
    logic [XLEN-1:0] lo_out;

    modport master (
        output start, op, op1, op2, flush,
        output hi_write, lo_write, wr_data,
        input  busy, done, div_by_zero,
        input  hi_out, lo_out
    );

    modport slave (
        input  start, op, op1, op2, flush,
        input  hi_write, lo_write, wr_data,
        output busy, done, div_by_zero,
        output hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_seq_unit.sv
// Radix-2 sequential MULT/MULTU/DIV/DIVU engine with HI/LO.
// One result bit per RUN cycle, sign fix-up in a final FIX cycle.
module muldiv_seq_unit #(
    parameter int XLEN = 32
) (
    input logic            clk,
    input logic            rst_n,
    muldiv_seq_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  count;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   op_b;
    logic [XLEN-1:0]   raw_a;
    logic              is_div;
    logic              neg_q;
    logic              neg_r;
    logic              dbz;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;
    logic              dbz_q;

    logic              in_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;

    assign in_signed = ~bus.op[0];
    assign a_neg     = in_signed & bus.op1[XLEN-1];
    assign b_neg     = in_signed & bus.op2[XLEN-1];
    assign a_mag     = a_neg ? -bus.op1 : bus.op1;
    assign b_mag     = b_neg ? -bus.op2 : bus.op2;

    logic [XLEN:0] mul_sum;
    logic [XLEN:0] div_shift;
    logic [XLEN:0] div_diff;
    logic [XLEN:0] div_next;
    logic          div_ge;
    logic          unused_div_top;

    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]}
                     + (acc[0] ? {1'b0, op_b} : '0);
    assign div_shift = {rem, acc[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, op_b};
    assign div_diff  = div_shift - {1'b0, op_b};
    assign div_next  = div_ge ? div_diff : div_shift;
    // Restored remainder is always below the divisor, so the top bit is 0.
    assign unused_div_top = div_next[XLEN];

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rmd;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

    assign prod = neg_q ? -acc : acc;
    assign quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rmd  = neg_r ? -rem : rem;

    always_comb begin
        fix_hi = prod[2*XLEN-1:XLEN];
        fix_lo = prod[XLEN-1:0];
        unique case (1'b1)
            is_div & dbz: begin
                fix_hi = raw_a;
                fix_lo = '1;
            end
            is_div & ~dbz: begin
                fix_hi = rmd;
                fix_lo = quo;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.flush)
                    state_d = IDLE;
                else if (count == CNT_W'(XLEN - 1))
                    state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            acc    <= '0;
            rem    <= '0;
            op_b   <= '0;
            raw_a  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.hi_write) hi_q <= bus.wr_data;
                    if (bus.lo_write) lo_q <= bus.wr_data;
                    if (bus.start) begin
                        count  <= '0;
                        rem    <= '0;
                        raw_a  <= bus.op1;
                        is_div <= bus.op[1];
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        dbz    <= bus.op[1] & (bus.op2 == '0);
                        // Divide: dividend shifts out of the low half.
                        // Multiply: multiplier shifts out of the low half.
                        if (bus.op[1]) begin
                            acc  <= {{XLEN{1'b0}}, a_mag};
                            op_b <= b_mag;
                        end else begin
                            acc  <= {{XLEN{1'b0}}, b_mag};
                            op_b <= a_mag;
                        end
                    end
                end
                RUN: begin
                    if (!bus.flush) begin
                        count <= count + 1'b1;
                        if (is_div) begin
                            rem <= div_next[XLEN-1:0];
                            acc[XLEN-1:0] <= {acc[XLEN-2:0], div_ge};
                        end else begin
                            acc <= {mul_sum, acc[XLEN-1:1]};
                        end
                    end
                end
                FIX: begin
                    if (!bus.flush) begin
                        hi_q   <= fix_hi;
                        lo_q   <= fix_lo;
                        done_q <= 1'b1;
                        dbz_q  <= dbz;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi_out      = hi_q;
    assign bus.lo_out      = lo_q;
endmodule

// File: tb/tb_muldiv_seq_unit.sv
// Directed bench for muldiv_seq_unit (XLEN=32).
// Each op starts on the falling edge of the previous done cycle.
module tb_muldiv_seq_unit;
    localparam int XLEN = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   lat;
    int   bcyc;
    logic seen;

    muldiv_seq_unit_if #(.XLEN(XLEN)) bus ();

    muldiv_seq_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // mode 0 plain, 1 start+MTLO+MTHI during RUN, 2 flush at 10, 3 stop at 15
    task automatic run_op(input logic [1:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input int mode,
                          output int l,
                          output int bc,
                          output logic sd);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.op1   = a;
        bus.op2   = b;
        @(posedge clk);
        #1;
        l  = 0;
        sd = 1'b0;
        bc = bus.busy ? 1 : 0;
        while (l < 40) begin
            @(negedge clk);
            bus.start    = 1'b0;
            bus.flush    = 1'b0;
            bus.hi_write = 1'b0;
            bus.lo_write = 1'b0;
            if (mode == 1 && l == 5) begin
                bus.start    = 1'b1;
                bus.op       = 2'b11;
                bus.op1      = 32'd100;
                bus.op2      = 32'd7;
                bus.hi_write = 1'b1;
                bus.lo_write = 1'b1;
                bus.wr_data  = 32'h0000DEAD;
            end
            if (mode == 2 && l == 10) bus.flush = 1'b1;
            @(posedge clk);
            #1;
            l++;
            if (bus.done) begin
                sd = 1'b1;
                break;
            end
            if (bus.busy) bc++;
            if (mode == 3 && l == 15) break;
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.op       = 2'b00;
        bus.op1      = '0;
        bus.op2      = '0;
        bus.flush    = 1'b0;
        bus.hi_write = 1'b0;
        bus.lo_write = 1'b0;
        bus.wr_data  = '0;
        #1;
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        check("rst_hi", bus.hi_out, 0);
        check("rst_lo", bus.lo_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        bus.hi_write = 1'b1;
        bus.wr_data  = 32'h00001234;
        @(posedge clk);
        #1;
        check("mthi_hi", bus.hi_out, 32'h00001234);
        check("mthi_lo", bus.lo_out, 0);
        @(negedge clk);
        bus.hi_write = 1'b0;

        run_op(2'b00, 32'hFFFFFFFD, 32'd7, 0, lat, bcyc, seen);
        check("mult_lat", 32'(lat), 33);
        check("mult_busy_cyc", 32'(bcyc), 33);
        check("mult_hi", bus.hi_out, 32'hFFFFFFFF);
        check("mult_lo", bus.lo_out, 32'hFFFFFFEB);
        check("mult_dbz", 32'(bus.div_by_zero), 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 32'(bus.done), 0);
        check("idle_busy", 32'(bus.busy), 0);

        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bcyc, seen);
        check("multu_lat", 32'(lat), 33);
        check("multu_hi", bus.hi_out, 32'hFFFFFFFE);
        check("multu_lo", bus.lo_out, 32'h00000001);

        run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, bcyc, seen);
        check("b2b_lat", 32'(lat), 33);
        check("mult_m1_hi", bus.hi_out, 0);
        check("mult_m1_lo", bus.lo_out, 32'h00000001);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 0, lat, bcyc, seen);
        check("div_n7_2_lat", 32'(lat), 33);
        check("div_n7_2_lo", bus.lo_out, 32'hFFFFFFFD);
        check("div_n7_2_hi", bus.hi_out, 32'hFFFFFFFF);

        run_op(2'b11, 32'd7, 32'd2, 0, lat, bcyc, seen);
        check("divu_7_2_lo", bus.lo_out, 32'd3);
        check("divu_7_2_hi", bus.hi_out, 32'd1);

        run_op(2'b10, 32'd7, 32'hFFFFFFFE, 0, lat, bcyc, seen);
        check("div_7_n2_lo", bus.lo_out, 32'hFFFFFFFD);
        check("div_7_n2_hi", bus.hi_out, 32'd1);

        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 0, lat, bcyc, seen);
        check("div_ovf_lo", bus.lo_out, 32'h80000000);
        check("div_ovf_hi", bus.hi_out, 0);
        check("div_ovf_dbz", 32'(bus.div_by_zero), 0);

        run_op(2'b11, 32'd5, 32'd0, 0, lat, bcyc, seen);
        check("divu_z_lat", 32'(lat), 33);
        check("divu_z_hi", bus.hi_out, 32'd5);
        check("divu_z_lo", bus.lo_out, 32'hFFFFFFFF);
        check("divu_z_dbz", 32'(bus.div_by_zero), 1);

        run_op(2'b10, 32'hFFFFFFFB, 32'd0, 0, lat, bcyc, seen);
        check("div_z_hi_raw", bus.hi_out, 32'hFFFFFFFB);
        check("div_z_lo", bus.lo_out, 32'hFFFFFFFF);
        check("div_z_dbz", 32'(bus.div_by_zero), 1);

        run_op(2'b01, 32'd3, 32'd4, 1, lat, bcyc, seen);
        check("ignore_lat", 32'(lat), 33);
        check("ignore_hi", bus.hi_out, 0);
        check("ignore_lo", bus.lo_out, 32'd12);

        run_op(2'b11, 32'd100, 32'd7, 2, lat, bcyc, seen);
        check("flush_no_done", 32'(seen), 0);
        check("flush_busy_cyc", 32'(bcyc), 11);
        check("flush_busy", 32'(bus.busy), 0);
        check("flush_hi", bus.hi_out, 0);
        check("flush_lo", bus.lo_out, 32'd12);

        run_op(2'b10, 32'hFFFFFFF9, 32'd2, 3, lat, bcyc, seen);
        check("pre_rst_busy", 32'(bus.busy), 1);
        @(negedge clk);
        bus.flush = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_done", 32'(bus.done), 0);
        check("mid_rst_dbz", 32'(bus.div_by_zero), 0);
        check("mid_rst_hi", bus.hi_out, 0);
        check("mid_rst_lo", bus.lo_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(2'b01, 32'd3, 32'd4, 0, lat, bcyc, seen);
        check("post_rst_lat", 32'(lat), 33);
        check("post_rst_lo", bus.lo_out, 32'd12);
        check("post_rst_hi", bus.hi_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
